// File: rtl/da_pkg.sv
// Shared types and helpers for the burst reader and timeout counter.
package da_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } burst_state_t;

    // Default header layout: channel tag in the MSBs, burst length in the low bits.
    localparam int unsigned HDR_W      = 8;
    localparam int unsigned HDR_LEN_W  = 3;
    localparam int unsigned HDR_CHAN_W = HDR_W - HDR_LEN_W;

    // Packs {chan, len}; the caller truncates the result to its header width.
    function automatic logic [31:0] make_header(input logic [31:0] chan,
                                                input logic [31:0] len,
                                                input int unsigned len_w);
        logic [31:0] len_mask;
        len_mask = (32'd1 << len_w) - 32'd1;
        return (chan << len_w) | (len & len_mask);
    endfunction

endpackage

// File: rtl/burst_timeout_counter.sv
// Saturating idle timer: clears on clr_i, counts while en_i, flags when it reaches TIMEOUT.
module burst_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q;

    // Next count: clear wins, otherwise count up and hold at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with a registered expiry flag that tracks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == CW'(TIMEOUT));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a sample FIFO in header+data bursts onto a valid/ready byte stream.
module fifo_burst_reader
    import da_pkg::*;
#(
    parameter int unsigned Nb        = 8,
    parameter int unsigned M         = 2,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CHAN_ID   = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [Nb-1:0] in_data,
    input  logic [M:0]    in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [Nb-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int unsigned LEN_W = M + 1;

    burst_state_t   state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic           out_valid_q, out_valid_d;
    logic [Nb-1:0]  out_data_q, out_data_d;
    logic           out_last_q, out_last_d;

    logic             tmr_clr, tmr_en, tmr_expired;
    logic             fifo_full, fifo_nonempty, in_xfer;
    logic [LEN_W-1:0] len_sel;
    logic [Nb-1:0]    header_word;

    burst_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Start conditions and header contents; a full burst takes priority over a flush.
    assign fifo_full     = (in_count >= LEN_W'(BURST_LEN));
    assign fifo_nonempty = (in_count != '0);
    assign len_sel       = fifo_full ? LEN_W'(BURST_LEN) : in_count;
    assign header_word   = Nb'(make_header(32'(CHAN_ID), 32'(len_sel), LEN_W));

    // Pop only while words remain and the output register is free or draining.
    assign in_ready = (state_q != IDLE) && (rem_q != '0) && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;

    // Next-state, burst counter, output register and idle-timer control.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_en  = fifo_nonempty && !fifo_full;
                tmr_clr = !fifo_nonempty;
                if (fifo_full || (tmr_expired && fifo_nonempty)) begin
                    tmr_clr     = 1'b1;
                    state_d     = HEADER;
                    rem_d       = len_sel;
                    out_data_d  = header_word;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end

            HEADER, DATA: begin
                tmr_clr = 1'b1;
                if (in_xfer) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    rem_d       = rem_q - LEN_W'(1);
                    out_last_d  = (rem_q == LEN_W'(1));
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end

                if (state_q == HEADER) begin
                    state_d = DATA;
                end else if ((rem_q == '0) && out_valid_q && out_ready && out_last_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: stimulus pushes expected beats, a monitor checks them.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_count;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .Nb        (8),
        .M         (2),
        .BURST_LEN (4),
        .CHAN_ID   (0),
        .TIMEOUT   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;   // required cycles since previous accepted beat, -1 = any
        int         at;    // required absolute cycle, -1 = any
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    bit bp_mode = 1'b0;
    int bp_idx = 0;
    int starve_gap = 0;
    int hold = 0;
    bit pop_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input int g, input int a);
        exp_t e;
        e.data = d;
        e.last = l;
        e.gap  = g;
        e.at   = a;
        exp_q.push_back(e);
    endtask

    // Header {CHAN_ID=0, len} followed by n sequential data words.
    task automatic exp_burst(input logic [7:0] first, input int n, input bit tight,
                             input int hdr_gap, input int hdr_at);
        push_exp(8'(n), 1'b0, hdr_gap, hdr_at);
        for (int i = 0; i < n; i++)
            push_exp(first + 8'(i), (i == n - 1), tight ? 1 : -1, -1);
    endtask

    task automatic drive();
        in_valid  = (src_q.size() > 0) && (hold == 0);
        in_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
        in_count  = (src_q.size() > 4) ? 3'd4 : 3'(src_q.size());
        out_ready = bp_mode ? !((bp_idx % 4 == 1) || (bp_idx % 4 == 2)) : 1'b1;
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(first + 8'(i));
        drive();
    endtask

    // One clock: sample the pop handshake mid-cycle, then update the FIFO model after the edge.
    task automatic step();
        @(negedge clk);
        pop_s = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (pop_s) begin
            void'(src_q.pop_front());
            if (starve_gap > 0) hold = starve_gap;
        end else if (hold > 0) begin
            hold--;
        end
        bp_idx++;
        drive();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: %0d beats still outstanding after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    // Monitor: compares accepted beats, stall stability, in_ready under stall, busy after last.
    bit         stall_v = 1'b0;
    logic [7:0] st_data;
    logic       st_last;
    bit         busy_chk = 1'b0;
    int         prev_acc = 0;
    exp_t       e_mon;

    always @(negedge clk) begin
        if (reset) begin
            stall_v  = 1'b0;
            busy_chk = 1'b0;
        end else begin
            if (busy_chk) begin
                chk("busy_after_last", 32'(busy), 32'd0);
                busy_chk = 1'b0;
            end
            if (stall_v) begin
                chk("stall_hold", {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, st_last, st_data});
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_stalled", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_beat: got data %0h last %0b with nothing expected (cycle %0d)",
                             out_data, out_last, cyc);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("beat", {23'd0, out_last, out_data}, {23'd0, e_mon.last, e_mon.data});
                    if (e_mon.gap >= 0) chk("beat_gap", 32'(cyc - prev_acc), 32'(e_mon.gap));
                    if (e_mon.at >= 0)  chk("beat_cycle", 32'(cyc), 32'(e_mon.at));
                end
                if (out_last) begin
                    chk("busy_on_last", 32'(busy), 32'd1);
                    busy_chk = 1'b1;
                end
                prev_acc = cyc;
            end
            stall_v = out_valid && !out_ready;
            st_data = out_data;
            st_last = out_last;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;

        // Reset state.
        reset = 1'b1;
        drive();
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Full burst: header one cycle after load, data on consecutive cycles.
        load(8'h11, 4);
        exp_burst(8'h11, 4, 1'b1, -1, cyc + 1);
        wait_done(40);

        // Timeout flush of two words, then a single word to show the timer restarted.
        load(8'hA1, 2);
        exp_burst(8'hA1, 2, 1'b1, -1, cyc + 9);
        wait_done(40);
        load(8'hB1, 1);
        exp_burst(8'hB1, 1, 1'b1, -1, cyc + 9);
        wait_done(40);

        // Timeout and full threshold in the same cycle: full-length burst.
        c0 = cyc;
        load(8'h51, 3);
        exp_burst(8'h51, 4, 1'b1, -1, c0 + 9);
        repeat (8) step();
        load(8'h54, 1);
        wait_done(40);

        // Back-pressure: out_ready pattern 1,0,0,1.
        bp_mode = 1'b1;
        bp_idx  = 0;
        load(8'h11, 4);
        exp_burst(8'h11, 4, 1'b0, -1, -1);
        wait_done(60);
        bp_mode = 1'b0;

        // Starved input: three dead cycles between words.
        starve_gap = 3;
        load(8'h41, 4);
        exp_burst(8'h41, 4, 1'b0, -1, -1);
        wait_done(80);
        starve_gap = 0;
        hold = 0;

        // Back-to-back: second header two cycles after the first last (one idle cycle).
        load(8'h31, 8);
        exp_burst(8'h31, 4, 1'b1, -1, cyc + 1);
        exp_burst(8'h35, 4, 1'b1, 2, -1);
        wait_done(60);

        // Reset after header and two data words.
        load(8'h61, 4);
        push_exp(8'h04, 1'b0, -1, cyc + 1);
        push_exp(8'h61, 1'b0, 1, -1);
        push_exp(8'h62, 1'b0, 1, -1);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL pre_reset_beats: %0d beats missing before reset", exp_q.size());
            exp_q.delete();
        end
        reset = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;
        src_q.delete();
        hold = 0;
        drive();
        repeat (2) step();
        load(8'h71, 4);
        exp_burst(8'h71, 4, 1'b1, -1, cyc + 1);
        wait_done(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Drains the read side of an asynchronous sample FIFO in fixed-size bursts for the host transmit path.
- Each burst goes out on a single valid/ready byte stream as one header word followed by the data words.
- Partial bursts are flushed after an idle timeout, so low-rate channels still make progress.
- Sits between the clock-crossing FIFO (read domain) and the host interface arbiter.

Parameters:
- Nb, 8: data word width; also the header width.
- M, 2: FIFO address bits; in_count is M+1 bits wide.
- BURST_LEN, 4: words per full burst; 1 <= BURST_LEN <= 2^M.
- CHAN_ID, 0: channel tag in the header; fits in Nb-(M+1) bits.
- TIMEOUT, 255: idle cycles before a partial burst is flushed; >= 1.

Ports:
- clk  in  1  read-domain clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  FIFO word available
- in_ready  out  1  pop request; a word transfers when in_valid & in_ready
- in_data  in  Nb  FIFO word
- in_count  in  M+1  FIFO occupancy (may lag the true value)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  Nb  header or data word
- out_last  out  1  marks the final word of a burst
- busy  out  1  high while state != IDLE

Behaviour:
- Reset values: state=IDLE, out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0; timer and word counter cleared.
- Output register rule: out_* may change only when out_valid=0 or out_ready=1, which is the standard stall rule.
- Length width: burst length len is held in M+1 bits.

IDLE:
- timer increments each cycle while 0 < in_count < BURST_LEN. It saturates at TIMEOUT and clears whenever in_count == 0.
- If in_count >= BURST_LEN: len = BURST_LEN, go to HEADER.
- Else if timer == TIMEOUT and in_count > 0: len = in_count (latched), go to HEADER.
- The timer clears on either exit.

HEADER:
- Load out_data = {CHAN_ID, len} (CHAN_ID in the MSBs, len in the low M+1 bits), out_valid=1, out_last=0.
- Go to DATA on the next cycle.

DATA:
- in_ready = (remaining > 0) && (!out_valid || out_ready).
- On each input transfer:
  - out_data <= in_data, out_valid <= 1, remaining decrements.
  - out_last = 1 when this is the final word.
- If out_ready=1 with no input transfer, out_valid drops to 0.
- When remaining == 0 and the last word has been accepted (out_valid & out_ready & out_last): go to IDLE, out_valid=0, out_last=0.

Boundary conditions:
- in_count lagging: in_count may under-report but never over-report. A latched len is therefore always deliverable; in_valid is waited on indefinitely.
- Back-pressure: out_ready low holds out_data/out_valid/out_last stable and forces in_ready low. No word is dropped or duplicated.
- Back-to-back bursts: returning to IDLE with in_count >= BURST_LEN starts the next HEADER on the following cycle. The minimum gap is 1 cycle with out_valid=0.
- TIMEOUT and full threshold in the same cycle: the full burst wins.
- Reset mid-burst: returns to IDLE at once; out_valid=0. Words already popped are lost; the bench treats this as acceptable.
- Throughput: 1 word/cycle in DATA when in_valid and out_ready are both held high.

Decomposition:
- Shared package da_pkg:
  - state enum burst_state_t {IDLE, HEADER, DATA}
  - function make_header(chan, len)
  - localparam header field widths
- Sub-module: burst_timeout_counter (saturating idle timer with clear/enable), reusable by the ADC path.

Test Plan:
- Full burst (BURST_LEN=4, 4 words 0x11..0x14 preloaded, out_ready=1):
  - Header 0x04, then 0x11, 0x12, 0x13, 0x14 on consecutive cycles.
  - out_last only on 0x14; busy low 1 cycle later.
- Timeout flush (TIMEOUT=8, 2 words 0xA1, 0xA2 in FIFO):
  - No output for 8 cycles.
  - Then header 0x02, 0xA1, 0xA2 (last); idle timer cleared.
- Back-pressure (toggle out_ready 1,0,0,1,... during a burst):
  - Output sequence identical to the full-burst case; out_data stable while stalled.
  - in_ready never high while out_valid & !out_ready.
- Starved input (in_count reports 4, in_valid gaps of 3 cycles between words):
  - Burst completes with all 4 words; no extra or duplicated words.
- Back-to-back (8 words preloaded):
  - Two bursts, headers 0x04/0x04; exactly one idle cycle between the first out_last and the second header.
- Reset mid-burst (assert reset after 2 data words):
  - Next cycle out_valid=0, busy=0, in_ready=0.
  - Next burst starts with a correct header.
